// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: sweeps x over an arithmetic grid, runs one func evaluation per point, streams (x, y) samples
`timescale 1ns/1ps
module func_sweep_ctrl #(
    parameter int          N_SAMPLES = 16,
    parameter logic [31:0] X_START   = 32'hFFFFFC00,
    parameter logic [31:0] X_STEP    = 32'h00000080,
    localparam int         IDX_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sweep_start,
    output logic             busy,
    output logic             sweep_done,
    output logic             sweep_ovf,
    output logic             start_func,
    output logic [31:0]      x_in,
    input  logic [63:0]      y_out,
    input  logic             func_done,
    input  logic             overflow,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [31:0]      s_x,
    output logic [63:0]      s_y,
    output logic             s_ovf,
    output logic             s_last,
    output logic [IDX_W-1:0] s_idx
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, EMIT, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      x_q, x_d, x_in_q, x_in_d, s_x_q, s_x_d;
    logic [IDX_W-1:0] idx_q, idx_d, s_idx_q, s_idx_d;
    logic [63:0]      s_y_q, s_y_d;
    logic             sweep_ovf_q, sweep_ovf_d, s_ovf_q, s_ovf_d, s_last_q, s_last_d;
    logic             busy_q, busy_d, sweep_done_q, sweep_done_d;
    logic             start_func_q, start_func_d, s_valid_q, s_valid_d;
    logic [31:0]      x_sum;
    logic             x_wrap;
    assign x_sum  = x_q + X_STEP;
    assign x_wrap = (x_q[31] == X_STEP[31]) && (x_sum[31] != x_q[31]);
    // next state and payload; every output is registered from the state being entered
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        idx_d       = idx_q;
        sweep_ovf_d = sweep_ovf_q;
        s_x_d       = s_x_q;
        s_y_d       = s_y_q;
        s_ovf_d     = s_ovf_q;
        s_last_d    = s_last_q;
        s_idx_d     = s_idx_q;
        case (state_q)
            IDLE: if (sweep_start) begin
                state_d     = ISSUE;
                x_d         = X_START;
                idx_d       = '0;
                sweep_ovf_d = 1'b0;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (func_done) begin
                state_d     = RELEASE;
                s_x_d       = x_q;
                s_y_d       = y_out;
                s_ovf_d     = overflow;
                s_idx_d     = idx_q;
                s_last_d    = idx_q == IDX_W'(N_SAMPLES - 1);
                sweep_ovf_d = sweep_ovf_q | overflow;
            end
            RELEASE: state_d = func_done ? RELEASE : EMIT;
            EMIT: if (s_ready) begin
                state_d = s_last_q ? DONE : ISSUE;
                if (!s_last_q) begin
                    x_d         = x_sum;
                    idx_d       = idx_q + IDX_W'(1);
                    sweep_ovf_d = sweep_ovf_q | x_wrap;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        x_in_d       = (state_d == ISSUE) ? x_d : x_in_q;
        start_func_d = (state_d == ISSUE) || (state_d == WAIT);
        s_valid_d    = state_d == EMIT;
        busy_d       = state_d != IDLE;
        sweep_done_d = state_d == DONE;
    end
    // state and registered outputs; reset aborts a sweep immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= X_START;
            idx_q        <= '0;
            sweep_ovf_q  <= 1'b0;
            x_in_q       <= '0;
            s_x_q        <= '0;
            s_y_q        <= '0;
            s_ovf_q      <= 1'b0;
            s_last_q     <= 1'b0;
            s_idx_q      <= '0;
            start_func_q <= 1'b0;
            s_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            idx_q        <= idx_d;
            sweep_ovf_q  <= sweep_ovf_d;
            x_in_q       <= x_in_d;
            s_x_q        <= s_x_d;
            s_y_q        <= s_y_d;
            s_ovf_q      <= s_ovf_d;
            s_last_q     <= s_last_d;
            s_idx_q      <= s_idx_d;
            start_func_q <= start_func_d;
            s_valid_q    <= s_valid_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign sweep_ovf  = sweep_ovf_q;
    assign start_func = start_func_q;
    assign x_in       = x_in_q;
    assign s_valid    = s_valid_q;
    assign s_x        = s_x_q;
    assign s_y        = s_y_q;
    assign s_ovf      = s_ovf_q;
    assign s_last     = s_last_q;
    assign s_idx      = s_idx_q;
endmodule
